// File: rtl/gg_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : gg_code_loader
// Brief    : Parses an ASCII Game Genie code list into single-cycle code-slot
//            packets, clearing every slot at the start of each list.
// Revision : 1.0 - initial release
// ============================================================================
module gg_code_loader #(
    parameter int MAX_CODES = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [37:0] code,
    output logic [3:0]  code_count,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] c_max_codes = 4'(MAX_CODES);
    localparam logic [3:0] c_last_slot = 4'(MAX_CODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RECV  = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;

    state_t          r_state,    w_state_next;
    logic [3:0]      r_slot_idx, w_slot_idx_next;
    logic [3:0]      r_len,      w_len_next;
    logic [7:0][3:0] r_nib,      w_nib_next;
    logic [3:0]      r_count,    w_count_next;
    logic            r_err,      w_err_next;
    logic [37:0]     r_pkt,      w_pkt_next;

    logic [7:0] w_upper;
    logic       w_is_letter;
    logic [3:0] w_letter_val;
    logic       w_is_term;
    logic       w_is_blank;
    logic       w_accept;
    logic       w_fin;

    // Fold lower case onto upper case before the letter lookup
    assign w_upper    = (in_data >= 8'h61 && in_data <= 8'h7A) ? (in_data - 8'h20) : in_data;
    assign w_is_term  = (in_data == 8'h0A) || (in_data == 8'h2C) || (in_data == 8'h00);
    assign w_is_blank = (in_data == 8'h20) || (in_data == 8'h0D);
    assign in_ready   = (r_state == ST_RECV) || (r_state == ST_SKIP);
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_is_letter  = 1'b1;
        w_letter_val = 4'd0;
        case (w_upper)
            "A": w_letter_val = 4'd0;
            "P": w_letter_val = 4'd1;
            "Z": w_letter_val = 4'd2;
            "L": w_letter_val = 4'd3;
            "G": w_letter_val = 4'd4;
            "I": w_letter_val = 4'd5;
            "T": w_letter_val = 4'd6;
            "Y": w_letter_val = 4'd7;
            "E": w_letter_val = 4'd8;
            "O": w_letter_val = 4'd9;
            "X": w_letter_val = 4'd10;
            "U": w_letter_val = 4'd11;
            "K": w_letter_val = 4'd12;
            "S": w_letter_val = 4'd13;
            "V": w_letter_val = 4'd14;
            "N": w_letter_val = 4'd15;
            default: w_is_letter = 1'b0;
        endcase
    end

    // Unscramble the letter nibbles into a full packet for slot idx
    function automatic logic [37:0] make_packet(input logic [7:0][3:0] n,
                                                input logic            long_code,
                                                input logic [3:0]      idx);
        logic [3:0]  l_nib;
        logic [14:0] addr;
        logic [7:0]  cmp;
        logic [7:0]  rep;
        l_nib = long_code ? n[7] : n[5];
        addr  = {n[3][2:0], n[4][3], n[5][2:0], n[1][3], n[2][2:0], n[3][3], n[4][2:0]};
        rep   = {n[0][3], n[1][2:0], l_nib[3], n[0][2:0]};
        cmp   = long_code ? {n[6][3], n[7][2:0], n[5][3], n[6][2:0]} : 8'd0;
        return {1'b1, idx, 1'b1, long_code, addr, cmp, rep};
    endfunction

    always_comb begin
        w_state_next    = r_state;
        w_slot_idx_next = r_slot_idx;
        w_len_next      = r_len;
        w_nib_next      = r_nib;
        w_count_next    = r_count;
        w_err_next      = r_err;
        w_pkt_next      = '0;
        w_fin           = 1'b0;

        case (r_state)
            ST_IDLE: ;
            ST_CLEAR: begin
                if (r_slot_idx == c_last_slot) begin
                    w_state_next = ST_RECV;
                end else begin
                    w_slot_idx_next = r_slot_idx + 4'd1;
                end
            end
            ST_RECV: begin
                if (w_accept) begin
                    if (w_is_letter) begin
                        if (r_len < 4'd8) begin
                            w_nib_next[r_len[2:0]] = w_letter_val;
                            w_len_next             = r_len + 4'd1;
                        end else begin
                            w_state_next = ST_SKIP;
                            w_err_next   = 1'b1;
                        end
                    end else if (w_is_term) begin
                        w_fin = 1'b1;
                    end else if (!w_is_blank) begin
                        w_state_next = ST_SKIP;
                        w_err_next   = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (w_accept && w_is_term) begin
                    w_state_next = ST_RECV;
                    w_len_next   = 4'd0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // load_end closes the line only after the same-cycle byte has been applied
        if (load_end && in_ready) begin
            if (w_state_next == ST_RECV) begin
                w_fin = 1'b1;
            end
            w_state_next = ST_IDLE;
        end

        if (w_fin) begin
            if (w_len_next == 4'd6 || w_len_next == 4'd8) begin
                if (r_count < c_max_codes) begin
                    w_pkt_next   = make_packet(w_nib_next, (w_len_next == 4'd8), r_count);
                    w_count_next = r_count + 4'd1;
                end else begin
                    w_err_next = 1'b1;
                end
            end else if (w_len_next != 4'd0) begin
                w_err_next = 1'b1;
            end
            w_len_next = 4'd0;
        end

        if (load_start) begin
            w_state_next    = ST_CLEAR;
            w_slot_idx_next = 4'd0;
            w_len_next      = 4'd0;
            w_nib_next      = '0;
            w_count_next    = 4'd0;
            w_err_next      = 1'b0;
            w_pkt_next      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_slot_idx <= 4'd0;
            r_len      <= 4'd0;
            r_nib      <= '0;
            r_count    <= 4'd0;
            r_err      <= 1'b0;
            r_pkt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_slot_idx <= w_slot_idx_next;
            r_len      <= w_len_next;
            r_nib      <= w_nib_next;
            r_count    <= w_count_next;
            r_err      <= w_err_next;
            r_pkt      <= w_pkt_next;
        end
    end

    // Clear packets come straight from the slot counter so they line up with busy
    assign code       = (r_state == ST_CLEAR) ? {1'b1, r_slot_idx, 33'd0} : r_pkt;
    assign busy       = (r_state == ST_CLEAR);
    assign code_count = r_count;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gg_code_loader.sv
`default_nettype none
// tb_gg_code_loader: directed and random code-list traffic compared each cycle
// against a queue-based model of the code-list rules.
module tb_gg_code_loader;

    localparam int MAX_CODES = 9;
    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RECV  = 2;
    localparam int M_SKIP  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_end;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [37:0] code;
    logic [3:0]  code_count;
    logic        busy;
    logic        err;

    gg_code_loader #(.MAX_CODES(MAX_CODES)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_end   (load_end),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .code       (code),
        .code_count (code_count),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          m_mode;
    int          m_slot;
    int          m_count;
    bit          m_err;
    int          m_nib[$];
    logic [37:0] m_pkt;
    logic [37:0] last_pkt;
    int          pkt_seen;
    logic [7:0]  tx_q[$];
    string       letters = "APZLGITYEOXUKSVN";

    localparam logic [37:0] c_sxiopo0 = {1'b1, 4'd0, 1'b1, 1'b0, 15'h11D9, 8'h00, 8'hAD};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gg_val(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= "a" && u <= "z") u = u - 8'd32;
        for (int i = 0; i < 16; i++) begin
            if (letters[i] == u) return i;
        end
        return -1;
    endfunction

    function automatic logic [37:0] build_pkt(input int idx);
        int n[8];
        int len, l_nib, addr, rep, cmp;
        len = m_nib.size();
        for (int i = 0; i < 8; i++) n[i] = (i < len) ? m_nib[i] : 0;
        l_nib = (len == 8) ? n[7] : n[5];
        addr  = ((n[3] & 7) << 12) | ((n[5] & 7) << 8) | ((n[4] & 8) << 8) |
                ((n[2] & 7) << 4)  | ((n[1] & 8) << 4) | (n[4] & 7) | (n[3] & 8);
        rep   = ((n[1] & 7) << 4) | ((n[0] & 8) << 4) | (n[0] & 7) | (l_nib & 8);
        cmp   = (len == 8) ? (((n[7] & 7) << 4) | ((n[6] & 8) << 4) | (n[6] & 7) | (n[5] & 8)) : 0;
        return {1'b1, 4'(idx), 1'b1, (len == 8), 15'(addr), 8'(cmp), 8'(rep)};
    endfunction

    task automatic model_terminate();
        int n;
        n = m_nib.size();
        if (n == 6 || n == 8) begin
            if (m_count < MAX_CODES) begin
                m_pkt = build_pkt(m_count);
                m_count++;
            end else begin
                m_err = 1'b1;
            end
        end else if (n != 0) begin
            m_err = 1'b1;
        end
        m_nib.delete();
    endtask

    task automatic model_byte(input logic [7:0] d);
        bit term;
        term = (d == 8'h0A) || (d == 8'h2C) || (d == 8'h00);
        if (m_mode == M_SKIP) begin
            if (term) begin
                m_mode = M_RECV;
                m_nib.delete();
            end
        end else if (gg_val(d) >= 0) begin
            if (m_nib.size() < 8) m_nib.push_back(gg_val(d));
            else begin
                m_mode = M_SKIP;
                m_err  = 1'b1;
            end
        end else if (term) begin
            model_terminate();
        end else if (d != 8'h20 && d != 8'h0D) begin
            m_mode = M_SKIP;
            m_err  = 1'b1;
        end
    endtask

    task automatic model_step(input bit ls, input bit le, input bit v, input logic [7:0] d);
        m_pkt = '0;
        if (ls) begin
            m_mode  = M_CLEAR;
            m_slot  = 0;
            m_count = 0;
            m_err   = 1'b0;
            m_nib.delete();
        end else if (m_mode == M_CLEAR) begin
            if (m_slot == MAX_CODES - 1) m_mode = M_RECV;
            else m_slot++;
        end else if (m_mode == M_RECV || m_mode == M_SKIP) begin
            if (v) model_byte(d);
            if (le) begin
                if (m_mode == M_RECV) model_terminate();
                m_mode = M_IDLE;
            end
        end
    endtask

    function automatic logic [37:0] exp_code();
        if (m_mode == M_CLEAR) return {1'b1, 4'(m_slot), 33'd0};
        return m_pkt;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit ls, input bit le, input bit v, input logic [7:0] d);
        load_start = ls;
        load_end   = le;
        in_valid   = v;
        in_data    = d;
        check_val("code",       code,       exp_code());
        check_val("code_count", code_count, 64'(m_count));
        check_val("busy",       busy,       64'(m_mode == M_CLEAR));
        check_val("in_ready",   in_ready,   64'(m_mode == M_RECV || m_mode == M_SKIP));
        check_val("err",        err,        64'(m_err));
        if (code[37] && !busy) begin
            last_pkt = code;
            pkt_seen++;
        end
        @(posedge clk);
        #1;
        model_step(ls, le, v, d);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        load_end   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_mode  = M_IDLE;
        m_slot  = 0;
        m_count = 0;
        m_err   = 1'b0;
        m_pkt   = '0;
        m_nib.delete();
    endtask

    task automatic do_load_start();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        while (m_mode == M_CLEAR) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d);
        if (m_mode == M_IDLE) do_load_start();
        while (m_mode == M_CLEAR) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic refill();
        int n, k;
        logic [7:0] ch;
        k = $urandom_range(0, 5);
        n = (k < 2) ? 6 : (k < 4) ? 8 : $urandom_range(0, 10);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 19) == 0) tx_q.push_back($urandom_range(0, 1) ? 8'h20 : 8'h0D);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0: tx_q.push_back(8'h42);
                    1: tx_q.push_back(8'h31);
                    default: tx_q.push_back(8'h7F);
                endcase
            end
            ch = letters[$urandom_range(0, 15)];
            if ($urandom_range(0, 1) == 1) ch = ch + 8'd32;
            tx_q.push_back(ch);
        end
        case ($urandom_range(0, 2))
            0: tx_q.push_back(8'h0A);
            1: tx_q.push_back(8'h2C);
            default: tx_q.push_back(8'h00);
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r;
        bit ls, le, v;
        logic [7:0] d;

        pkt_seen = 0;
        last_pkt = '0;
        do_reset();
        check_val("rst_code",     code,       0);
        check_val("rst_count",    code_count, 0);
        check_val("rst_busy",     busy,       0);
        check_val("rst_err",      err,        0);
        check_val("rst_in_ready", in_ready,   0);

        // Slot clear sequence
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < MAX_CODES; i++) begin
            check_val("clr_code", code, {1'b1, 4'(i), 33'd0});
            check_val("clr_busy", busy, 1);
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check_val("clr_done_busy",  busy,     0);
        check_val("clr_done_ready", in_ready, 1);

        // Six- and eight-letter decodes
        send_str("SXIOPO\n");
        check_val("sxiopo_code",  code,       c_sxiopo0);
        check_val("sxiopo_count", code_count, 1);
        send_str("nnnnnnnn,");
        check_val("all_n", code, {1'b1, 4'd1, 1'b1, 1'b1, 15'h7FFF, 8'hFF, 8'hFF});
        send_str("AAAAAAAA,");
        check_val("all_a", code, {1'b1, 4'd2, 1'b1, 1'b1, 15'h0000, 8'h00, 8'h00});

        // Short line and bad character
        do_load_start();
        pkt_seen = 0;
        send_str("SXIOP\n");
        check_val("short_err",  err,  1);
        check_val("short_code", code, 0);
        send_str("SXIBPO\n");
        check_val("bad_code", code, 0);
        check_val("bad_pkts", pkt_seen, 0);
        send_str("SXIOPO\n");
        check_val("after_err_code", code, c_sxiopo0);
        check_val("after_err_err",  err,  1);

        // Overflow past MAX_CODES
        do_load_start();
        pkt_seen = 0;
        repeat (MAX_CODES + 1) send_str("SXIOPO\n");
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_val("ovf_pkts",  pkt_seen,        MAX_CODES);
        check_val("ovf_count", code_count,      MAX_CODES);
        check_val("ovf_err",   err,             1);
        check_val("ovf_last",  last_pkt[36:33], MAX_CODES - 1);

        // load_end flushes a partial line; load_start drops a same-cycle byte
        do_load_start();
        send_str("SXIOPO");
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check_val("end_flush_code",  code,     c_sxiopo0);
        check_val("end_flush_ready", in_ready, 0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, "A");
        check_val("ls_drop_busy", busy, 1);
        check_val("ls_drop_code", code, {1'b1, 4'd0, 33'd0});
        while (m_mode == M_CLEAR) step(1'b0, 1'b0, 1'b0, 8'h00);
        send_str("SXIOPO\n");
        check_val("ls_drop_pkt", code, c_sxiopo0);
        check_val("ls_drop_err", err,  0);

        // Reset in the middle of a line and in the middle of a clear
        send_str("SXIO");
        do_reset();
        check_val("mid_rst_code",  code,     0);
        check_val("mid_rst_ready", in_ready, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();
        check_val("clr_rst_busy", busy, 0);
        check_val("clr_rst_code", code, 0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (tx_q.size() == 0) refill();
            r  = $urandom_range(0, 999);
            ls = (r < 5);
            le = (r >= 5 && r < 15);
            v  = ($urandom_range(0, 3) != 0);
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) ls = 1'b1;
            d  = v ? tx_q[0] : 8'($urandom_range(0, 255));
            if (v && (m_mode == M_RECV || m_mode == M_SKIP)) void'(tx_q.pop_front());
            step(ls, le, v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
